// File: rtl/ysyx_23060251_pipe_pkg.sv
// rtl/ysyx_23060251_pipe_pkg.sv - shared pipeline-stage types and constants
package ysyx_23060251_pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // addi x0,x0,0 in the low word so an empty stage decodes as a NOP
  localparam logic [63:0] BUBBLE_DEFAULT = {32'h0000_0000, NOP_INST};

endpackage

// File: rtl/stall_counter.sv
// rtl/stall_counter.sv - saturating cycle counter with synchronous clear
module stall_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/stage_skid_reg.sv
// rtl/stage_skid_reg.sv - pipeline stage register with two-entry skid buffer
// Optional flush port enabled by YSYX_23060251_STAGE_FLUSH_EN.
module stage_skid_reg
  import ysyx_23060251_pipe_pkg::*;
#(
  parameter int unsigned       DATA_W = 64,
  parameter logic [DATA_W-1:0] BUBBLE = DATA_W'(BUBBLE_DEFAULT),
  parameter int unsigned       CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              out_ready_i,
`ifdef YSYX_23060251_STAGE_FLUSH_EN
  input  logic              flush_i,
`endif
  output logic [CNT_W-1:0]  stall_cnt_o
);

  stage_state_e      state_q, state_d;
  logic              rdy_q, rdy_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              push;
  logic              pop;
  logic              stall_clr;

  assign out_valid_o = (state_q != ST_EMPTY);
  assign in_ready_o  = rdy_q;
  assign out_data_o  = out_valid_o ? main_data_q : BUBBLE;

  assign push = in_valid_i & rdy_q;
  assign pop  = out_valid_o & out_ready_i;

`ifdef YSYX_23060251_STAGE_FLUSH_EN
  assign stall_clr = flush_i;
`else
  assign stall_clr = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;
    case (state_q)
      ST_EMPTY: begin
        if (push) begin
          state_d     = ST_ONE;
          main_data_d = in_data_i;
        end
      end
      ST_ONE: begin
        if (push && pop) begin
          main_data_d = in_data_i;
        end else if (push) begin
          state_d     = ST_FULL;
          skid_data_d = in_data_i;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // rdy_q is low here, so the only event is draining the skid entry
        if (pop) begin
          state_d     = ST_ONE;
          main_data_d = skid_data_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
`ifdef YSYX_23060251_STAGE_FLUSH_EN
    if (flush_i) begin
      state_d = ST_EMPTY;
    end
`endif
    rdy_d = (state_d != ST_FULL);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_EMPTY;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
    end
  end

  // Payload registers carry no reset; the valid state qualifies them.
  always_ff @(posedge clk_i) begin
    main_data_q <= main_data_d;
    skid_data_q <= skid_data_d;
  end

  stall_counter #(
    .W(CNT_W)
  ) u_stall_counter (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (out_valid_o & ~out_ready_i),
    .clr_i (stall_clr),
    .cnt_o (stall_cnt_o)
  );

endmodule

// File: doc/stage_skid_reg.md
# stage_skid_reg

Parametrised pipeline stage register with a two-entry skid buffer. It is the successor to the single-entry IF/ID stage register and sits between any two stages: IFU→IDU, IDU→EXU, and so on. It gives full-throughput valid/ready handshaking with a registered upstream ready. A bubble value is presented whenever the stage is empty, and a synchronous flush clears the stage for redirects.

## Interface
Parameters:
- DATA_W, 64, payload width (e.g. {pc, inst}).
- BUBBLE, 64'h0000_0000_0000_0013, value driven on out_data_o when the stage is empty; its low 32 bits are a NOP (addi x0,x0,0).
- CNT_W, 16, width of the stall counter.

Ports:
- clk_i, input, 1, the single clock.
- rst_i, input, 1, asynchronous, active-low reset.
- in_valid_i, input, 1, upstream beat valid.
- in_data_i, input, DATA_W, upstream payload.
- in_ready_o, output, 1, stage can accept a beat. Driven directly from a flop.
- out_valid_o, output, 1, downstream beat valid.
- out_data_o, output, DATA_W, head payload, or BUBBLE when out_valid_o=0.
- out_ready_i, input, 1, downstream accepts the head.
- flush_i, input, 1, discard all contents. Present only with the flush feature.
- stall_cnt_o, output, CNT_W, saturating count of cycles with out_valid_o & ~out_ready_i.

## Operation
- Storage: main entry (head) and skid entry, each with a payload and a valid bit.
- States:
  - EMPTY: no valid entries.
  - ONE: main valid.
  - FULL: main and skid valid.
- Handshakes: push = in_valid_i & in_ready_o; pop = out_valid_o & out_ready_i.
- Outputs by state:
  - out_valid_o = main valid.
  - in_ready_o = ~skid valid, registered.
- Transitions:
  - EMPTY + push → ONE; main ← in_data_i.
  - ONE + push, no pop → FULL; skid ← in_data_i.
  - ONE + push + pop → ONE; main ← in_data_i.
  - ONE + pop, no push → EMPTY.
  - FULL + pop → ONE; main ← skid. No push is possible in FULL because in_ready_o=0.
- Data order is strictly FIFO. No beat is dropped or duplicated.
- out_data_o = main valid ? main payload : BUBBLE.
- Payload flops are not reset; only the valid bits, in_ready_o and the counter are reset.
- Stall counter:
  - Increments each cycle out_valid_o & ~out_ready_i.
  - Saturates at all-ones and never wraps.
  - Clears to 0 on flush (flush feature only).

## Timing
- Reset (rst_i=0, asynchronous) forces:
  - out_valid_o=0, out_data_o=BUBBLE
  - in_ready_o=1
  - stall_cnt_o=0
  - state EMPTY
- The block leaves reset on the first clk_i edge after rst_i rises.
- Latency: a beat pushed at edge N appears on out_valid_o/out_data_o after edge N; it can pop in the same cycle.
- Throughput: one beat per cycle sustained while out_ready_i=1.
- in_ready_o has no combinational path from out_ready_i. It deasserts the cycle after the skid fills and reasserts the cycle after a pop from FULL.
- Upstream rule: in_data_i must hold stable while in_valid_i=1 and in_ready_o=0. Downstream may toggle out_ready_i freely.
- Reset asserted mid-operation discards all contents immediately, without waiting for a clock edge.

## Configuration
- Macro: YSYX_23060251_STAGE_FLUSH_EN.
- Defined: flush_i port exists. At the clock edge where flush_i=1:
  - Both valid bits clear and the state goes to EMPTY.
  - in_ready_o becomes 1 and stall_cnt_o becomes 0.
  - A simultaneous push or pop is ignored: the incoming beat is discarded.
  - Flush takes priority over every other event.
- Undefined: the flush_i port is absent and the state machine has no flush logic.

## Structure
- The shared package ysyx_23060251_pipe_pkg holds:
  - the state enum (EMPTY, ONE, FULL)
  - localparam NOP_INST = 32'h0000_0013
  - the default BUBBLE constant
- One sub-module: stall_counter, a parametrised saturating counter with inc and clr inputs.
- The skid datapath and state machine live in the top module.

## Test plan
- Reset release, idle: out_valid_o=0, out_data_o=64'h13, in_ready_o=1, stall_cnt_o=0.
- Stream 0x1..0x8 with out_ready_i=1 held: outputs 0x1..0x8 on consecutive cycles, each one cycle after its push, with in_ready_o constantly 1.
- Push 0xA, 0xB with out_ready_i=0:
  - State reaches FULL and in_ready_o=0 the next cycle.
  - 0xC is held off.
  - stall_cnt_o counts up each stalled cycle.
  - On release, output order is 0xA, 0xB, 0xC.
- Random in_valid_i/out_ready_i for 10k cycles versus a reference queue model: no loss, duplication or reordering, and occupancy never exceeds 2.
- CNT_W=4, out_ready_i=0 for 20 cycles with a valid head: stall_cnt_o saturates at 0xF and stays there.
- With YSYX_23060251_STAGE_FLUSH_EN, state FULL (0xA, 0xB), flush_i=1 with a simultaneous push of 0xC:
  - Next cycle: out_valid_o=0, out_data_o=BUBBLE, in_ready_o=1, stall_cnt_o=0.
  - 0xC never appears on the output.
